// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump redirect with IF/ID flush sequencing and branch statistics.
// Ports: clk, rst, in_* (stall/branch/jump/sequential/target/halt), out_* (redirect, flush, halted, counters).
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_stall,
  input  logic              in_branch,
  input  logic              in_jump,
  input  logic              in_sequential,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_halt,
  output logic              out_redirect,
  output logic [ADDR_W-1:0] out_redirect_pc,
  output logic              out_flush,
  output logic              out_halted,
  output logic [CNT_W-1:0]  out_cycle_cnt,
  output logic [CNT_W-1:0]  out_cond_cnt,
  output logic [CNT_W-1:0]  out_taken_cnt,
  output logic [CNT_W-1:0]  out_jump_cnt
);

  localparam int RW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [RW-1:0]     rem, rem_n;
  logic              redirect_n;
  logic [ADDR_W-1:0] pc_n;
  logic              flush_n;
  logic              halted_n;
  logic [CNT_W-1:0]  cycle_n;
  logic [CNT_W-1:0]  cond_n;
  logic [CNT_W-1:0]  taken_n;
  logic [CNT_W-1:0]  jump_n;
  logic              take;

  assign take = in_jump | (in_branch & ~in_sequential);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      rem             <= '0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
      out_flush       <= 1'b0;
      out_halted      <= 1'b0;
      out_cycle_cnt   <= '0;
      out_cond_cnt    <= '0;
      out_taken_cnt   <= '0;
      out_jump_cnt    <= '0;
    end else begin
      state           <= state_n;
      rem             <= rem_n;
      out_redirect    <= redirect_n;
      out_redirect_pc <= pc_n;
      out_flush       <= flush_n;
      out_halted      <= halted_n;
      out_cycle_cnt   <= cycle_n;
      out_cond_cnt    <= cond_n;
      out_taken_cnt   <= taken_n;
      out_jump_cnt    <= jump_n;
    end
  end

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    redirect_n = 1'b0;
    pc_n       = out_redirect_pc;
    flush_n    = 1'b0;
    halted_n   = out_halted;
    cond_n     = out_cond_cnt;
    taken_n    = out_taken_cnt;
    jump_n     = out_jump_cnt;
    cycle_n    = out_cycle_cnt;
    if (state != HALTED)
      cycle_n = out_cycle_cnt + CNT_W'(1);

    unique case (state)
      RUN: begin
        if (!in_stall) begin
          if (in_halt) begin
            // Halt wins over a branch/jump in the same slot.
            state_n  = HALTED;
            halted_n = 1'b1;
          end else begin
            // Branch+jump together counts as a jump only.
            if (in_jump) begin
              jump_n = out_jump_cnt + CNT_W'(1);
            end else if (in_branch) begin
              cond_n = out_cond_cnt + CNT_W'(1);
              if (!in_sequential)
                taken_n = out_taken_cnt + CNT_W'(1);
            end
            if (take) begin
              redirect_n = 1'b1;
              pc_n       = in_target;
              flush_n    = 1'b1;
              state_n    = FLUSH;
              rem_n      = RW'(FLUSH_CYCLES - 1);
            end
          end
        end
      end
      FLUSH: begin
        // Squashed slots: counts down regardless of stall.
        if (rem == '0) begin
          state_n = RUN;
        end else begin
          rem_n   = rem - 1'b1;
          flush_n = 1'b1;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed testbench for branch_redirect_ctrl.
// Drives a linear sequence of vectors; checks via immediate assertions.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_stall, in_branch, in_jump, in_sequential, in_halt;
  logic [31:0] in_target;
  logic        redirect, flush, halted;
  logic [31:0] redirect_pc, cycle_cnt, cond_cnt, taken_cnt, jump_cnt;
  logic        s_redirect, s_flush, s_halted;
  logic [31:0] s_pc;
  logic [3:0]  s_cycle, s_cond, s_taken, s_jump;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .in_stall(in_stall), .in_branch(in_branch),
    .in_jump(in_jump), .in_sequential(in_sequential),
    .in_target(in_target), .in_halt(in_halt),
    .out_redirect(redirect), .out_redirect_pc(redirect_pc),
    .out_flush(flush), .out_halted(halted),
    .out_cycle_cnt(cycle_cnt), .out_cond_cnt(cond_cnt),
    .out_taken_cnt(taken_cnt), .out_jump_cnt(jump_cnt)
  );

  branch_redirect_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_stall(in_stall), .in_branch(in_branch),
    .in_jump(in_jump), .in_sequential(in_sequential),
    .in_target(in_target), .in_halt(in_halt),
    .out_redirect(s_redirect), .out_redirect_pc(s_pc),
    .out_flush(s_flush), .out_halted(s_halted),
    .out_cycle_cnt(s_cycle), .out_cond_cnt(s_cond),
    .out_taken_cnt(s_taken), .out_jump_cnt(s_jump)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_stall = 0; in_branch = 0; in_jump = 0;
    in_sequential = 0; in_halt = 0; in_target = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_redirect", redirect, 0);
    chk("rst_flush", flush, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cycle", cycle_cnt, 0);
    rst = 1'b0;

    // 1: ten idle cycles
    repeat (10) step();
    chk("t1_cycle", cycle_cnt, 10);
    chk("t1_cycle4", s_cycle, 10);
    chk("t1_cond", cond_cnt, 0);
    chk("t1_taken", taken_cnt, 0);
    chk("t1_jump", jump_cnt, 0);
    chk("t1_redirect", redirect, 0);
    chk("t1_flush", flush, 0);

    // 2: taken conditional branch
    in_branch = 1; in_sequential = 0; in_target = 32'h40;
    step();
    idle();
    chk("t2_redirect", redirect, 1);
    chk("t2_pc", redirect_pc, 32'h40);
    chk("t2_flush0", flush, 1);
    chk("t2_cond", cond_cnt, 1);
    chk("t2_taken", taken_cnt, 1);
    chk("t2_cycle", cycle_cnt, 11);
    step();
    chk("t2_redirect_pulse", redirect, 0);
    chk("t2_flush1", flush, 1);
    step();
    chk("t2_flush_drop", flush, 0);
    chk("t2_cycle2", cycle_cnt, 13);

    // 3: not-taken conditional branch
    in_branch = 1; in_sequential = 1; in_target = 32'h80;
    step();
    idle();
    chk("t3_redirect", redirect, 0);
    chk("t3_flush", flush, 0);
    chk("t3_cond", cond_cnt, 2);
    chk("t3_taken", taken_cnt, 1);
    chk("t3_pc_hold", redirect_pc, 32'h40);

    // 4: jump, then branch offered during flush
    in_jump = 1; in_target = 32'h100;
    step();
    chk("t4_redirect", redirect, 1);
    chk("t4_pc", redirect_pc, 32'h100);
    chk("t4_jump", jump_cnt, 1);
    in_jump = 0; in_branch = 1; in_sequential = 0; in_target = 32'h200;
    step();
    chk("t4_flush1", flush, 1);
    chk("t4_no_redirect", redirect, 0);
    step();
    idle();
    chk("t4_flush_drop", flush, 0);
    chk("t4_cond", cond_cnt, 2);
    chk("t4_taken", taken_cnt, 1);
    chk("t4_pc", redirect_pc, 32'h100);

    // stall in RUN: branch not evaluated
    in_stall = 1; in_branch = 1; in_sequential = 0; in_target = 32'h300;
    step();
    idle();
    chk("stall_redirect", redirect, 0);
    chk("stall_cond", cond_cnt, 2);
    chk("stall_cycle", cycle_cnt, 18);

    // branch+jump together counts as jump
    in_branch = 1; in_jump = 1; in_target = 32'h120;
    step();
    idle();
    chk("bj_jump", jump_cnt, 2);
    chk("bj_cond", cond_cnt, 2);
    chk("bj_pc", redirect_pc, 32'h120);
    step(); step();
    chk("bj_flush_drop", flush, 0);

    // 5: halt with jump in same cycle
    in_halt = 1; in_jump = 1; in_target = 32'h500;
    step();
    chk("t5_halted", halted, 1);
    chk("t5_jump", jump_cnt, 2);
    chk("t5_redirect", redirect, 0);
    chk("t5_cycle", cycle_cnt, 22);
    in_halt = 0; in_branch = 1; in_sequential = 0;
    repeat (3) step();
    idle();
    chk("t5_cycle_frozen", cycle_cnt, 22);
    chk("t5_cond_frozen", cond_cnt, 2);
    chk("t5_flush", flush, 0);
    chk("t5_halted_sticky", halted, 1);

    // 6: reset from HALTED, then reset mid-flush
    rst = 1'b1;
    #1;
    chk("t6_rst_halted", halted, 0);
    rst = 1'b0;
    in_jump = 1; in_target = 32'h44;
    step();
    idle();
    chk("t6_flush_pre", flush, 1);
    chk("t6_redirect_pre", redirect, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_redirect", redirect, 0);
    chk("t6_rst_pc", redirect_pc, 0);
    chk("t6_rst_jump", jump_cnt, 0);
    #1 rst = 1'b0;
    step();
    chk("t6_cycle1", cycle_cnt, 1);
    chk("t6_flush_post", flush, 0);
    repeat (15) step();
    chk("t6_cycle16", cycle_cnt, 16);
    chk("t6_wrap4", s_cycle, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
